// File: rtl/alu_pkg.sv
// Shared types for the ALU command issue block: FSM encoding, widths and
// the command record {select, A, in0, in1} in the order the FIFO word is packed.
package alu_pkg;

  localparam int SEL_W      = 3;
  localparam int DEF_DATA_W = 32;
  localparam int LAT_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic [SEL_W-1:0]      select;
    logic [DEF_DATA_W-1:0] a;
    logic [DEF_DATA_W-1:0] in0;
    logic [DEF_DATA_W-1:0] in1;
  } alu_cmd_t;

  function automatic int cmd_width(input int data_w);
    return SEL_W + 3 * data_w;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// In-order command FIFO: flat word storage, wrapping pointers and an
// occupancy count that drives full/empty.
module alu_cmd_fifo #(
  parameter int WIDTH = 99,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign o_full  = (count_q == CNT_FULL);
  assign o_empty = (count_q == '0);
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;
  assign o_rdata = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
    else if (!push_ok && pop_ok) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage holds data only; stale entries are unreachable once pointers reset.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr_q] <= i_wdata;
  end

endmodule

// File: rtl/alu_cmd_issue.sv
// Queues ALU commands, issues one at a time onto registered ALU inputs,
// waits ALU_LAT clocks and holds the captured result until it is accepted.
module alu_cmd_issue
  import alu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [SEL_W-1:0]  i_select,
  input  logic [DATA_W-1:0] i_A,
  input  logic [DATA_W-1:0] i_in0,
  input  logic [DATA_W-1:0] i_in1,
  output logic [SEL_W-1:0]  o_alu_select,
  output logic [DATA_W-1:0] o_alu_A,
  output logic [DATA_W-1:0] o_alu_in0,
  output logic [DATA_W-1:0] o_alu_in1,
  input  logic [DATA_W-1:0] i_alu_out,
  output logic [DATA_W-1:0] o_result,
  output logic              o_result_valid,
  input  logic              i_result_ready,
  output logic              o_busy
);

  localparam int CMD_W = cmd_width(DATA_W);

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] in0_q, in0_d;
  logic [DATA_W-1:0] in1_q, in1_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              rvalid_q, rvalid_d;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [CMD_W-1:0]  fifo_rdata;
  logic [SEL_W-1:0]  head_sel;
  logic [DATA_W-1:0] head_a, head_in0, head_in1;

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (i_cmd_valid),
    .i_wdata ({i_select, i_A, i_in0, i_in1}),
    .i_pop   (fifo_pop),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign {head_sel, head_a, head_in0, head_in1} = fifo_rdata;

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == '0) state_d = ST_HOLD;
      ST_HOLD: begin
        if (i_result_ready) state_d = fifo_empty ? ST_IDLE : ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // HOLD pops on the same edge the result is taken, giving back-to-back issue.
  always_comb begin
    fifo_pop = !fifo_empty &&
               ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && i_result_ready));
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    a_d      = a_q;
    in0_d    = in0_q;
    in1_d    = in1_q;
    result_d = result_q;
    rvalid_d = rvalid_q;
    if (fifo_pop) begin
      sel_d = head_sel;
      a_d   = head_a;
      in0_d = head_in0;
      in1_d = head_in1;
      cnt_d = LAT_W'(ALU_LAT);
    end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - LAT_W'(1);
    end
    if ((state_q == ST_WAIT) && (cnt_q == '0)) begin
      result_d = i_alu_out;
      rvalid_d = 1'b1;
    end else if ((state_q == ST_HOLD) && i_result_ready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q    <= '0;
      sel_q    <= '0;
      a_q      <= '0;
      in0_q    <= '0;
      in1_q    <= '0;
      result_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      a_q      <= a_d;
      in0_q    <= in0_d;
      in1_q    <= in1_d;
      result_q <= result_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign o_cmd_ready    = !fifo_full;
  assign o_alu_select   = sel_q;
  assign o_alu_A        = a_q;
  assign o_alu_in0      = in0_q;
  assign o_alu_in1      = in1_q;
  assign o_result       = result_q;
  assign o_result_valid = rvalid_q;
  assign o_busy         = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue: two instances (ALU_LAT=0 at index 0,
// ALU_LAT=1 at index 1), each with an adder ALU stub of matching latency.
module tb_alu_cmd_issue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        cmd_valid [2];
  logic [2:0]  sel       [2];
  logic [31:0] a         [2];
  logic [31:0] in0       [2];
  logic [31:0] in1       [2];
  logic        res_ready [2];

  logic        cmd_ready [2];
  logic [2:0]  alu_sel   [2];
  logic [31:0] alu_a     [2];
  logic [31:0] alu_in0   [2];
  logic [31:0] alu_in1   [2];
  logic [31:0] result    [2];
  logic        res_valid [2];
  logic        busy      [2];

  logic [31:0] alu_out0;
  logic [31:0] alu_out1;

  int total = 0;
  int bad   = 0;

  logic [31:0] t_in0 [6] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
  logic [31:0] t_in1 [6] = '{32'h0, 32'h20, 32'h40, 32'h60, 32'h80, 32'hA0};
  logic [31:0] t_exp [5] = '{32'h1001, 32'h1022, 32'h1043, 32'h1064, 32'h1085};

  assign alu_out0 = alu_in0[0] + alu_in1[0] + alu_a[0];
  always @(posedge clk) alu_out1 <= alu_in0[1] + alu_in1[1] + alu_a[1];

  alu_cmd_issue #(.DATA_W(32), .DEPTH(4), .ALU_LAT(0)) u_dut0 (
    .i_clk (clk), .i_reset (rst[0]),
    .i_cmd_valid (cmd_valid[0]), .o_cmd_ready (cmd_ready[0]),
    .i_select (sel[0]), .i_A (a[0]), .i_in0 (in0[0]), .i_in1 (in1[0]),
    .o_alu_select (alu_sel[0]), .o_alu_A (alu_a[0]),
    .o_alu_in0 (alu_in0[0]), .o_alu_in1 (alu_in1[0]),
    .i_alu_out (alu_out0),
    .o_result (result[0]), .o_result_valid (res_valid[0]),
    .i_result_ready (res_ready[0]), .o_busy (busy[0])
  );

  alu_cmd_issue #(.DATA_W(32), .DEPTH(4), .ALU_LAT(1)) u_dut1 (
    .i_clk (clk), .i_reset (rst[1]),
    .i_cmd_valid (cmd_valid[1]), .o_cmd_ready (cmd_ready[1]),
    .i_select (sel[1]), .i_A (a[1]), .i_in0 (in0[1]), .i_in1 (in1[1]),
    .o_alu_select (alu_sel[1]), .o_alu_A (alu_a[1]),
    .o_alu_in0 (alu_in0[1]), .o_alu_in1 (alu_in1[1]),
    .i_alu_out (alu_out1),
    .o_result (result[1]), .o_result_valid (res_valid[1]),
    .i_result_ready (res_ready[1]), .o_busy (busy[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input int k, input string tag);
    chk($sformatf("%s_k%0d_sel", tag, k), 64'(alu_sel[k]), 64'd0);
    chk($sformatf("%s_k%0d_A", tag, k), 64'(alu_a[k]), 64'd0);
    chk($sformatf("%s_k%0d_in0", tag, k), 64'(alu_in0[k]), 64'd0);
    chk($sformatf("%s_k%0d_in1", tag, k), 64'(alu_in1[k]), 64'd0);
    chk($sformatf("%s_k%0d_result", tag, k), 64'(result[k]), 64'd0);
    chk($sformatf("%s_k%0d_rvalid", tag, k), 64'(res_valid[k]), 64'd0);
    chk($sformatf("%s_k%0d_busy", tag, k), 64'(busy[k]), 64'd0);
    chk($sformatf("%s_k%0d_cmdrdy", tag, k), 64'(cmd_ready[k]), 64'd1);
  endtask

  task automatic drive_tbl(input int k, input int i);
    cmd_valid[k] = 1'b1;
    sel[k]       = 3'(i);
    a[k]         = 32'h1000;
    in0[k]       = t_in0[i];
    in1[k]       = t_in1[i];
  endtask

  // k doubles as the instance's ALU latency.
  task automatic single(input int k);
    res_ready[k] = 1'b0;
    cmd_valid[k] = 1'b1;
    sel[k] = 3'b001; in0[k] = 32'hD4; in1[k] = 32'hD5; a[k] = 32'hD6;
    chk($sformatf("single_k%0d_cmdrdy", k), 64'(cmd_ready[k]), 64'd1);
    tick();
    cmd_valid[k] = 1'b0;
    chk($sformatf("single_k%0d_t1_sel", k), 64'(alu_sel[k]), 64'd0);
    chk($sformatf("single_k%0d_t1_busy", k), 64'(busy[k]), 64'd1);
    tick();
    chk($sformatf("single_k%0d_t2_sel", k), 64'(alu_sel[k]), 64'd1);
    chk($sformatf("single_k%0d_t2_A", k), 64'(alu_a[k]), 64'hD6);
    chk($sformatf("single_k%0d_t2_in0", k), 64'(alu_in0[k]), 64'hD4);
    chk($sformatf("single_k%0d_t2_in1", k), 64'(alu_in1[k]), 64'hD5);
    repeat (k) tick();
    chk($sformatf("single_k%0d_early_rvalid", k), 64'(res_valid[k]), 64'd0);
    tick();
    chk($sformatf("single_k%0d_rvalid", k), 64'(res_valid[k]), 64'd1);
    chk($sformatf("single_k%0d_result", k), 64'(result[k]), 64'h27F);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("bp_k%0d_c%0d_rvalid", k, c), 64'(res_valid[k]), 64'd1);
      chk($sformatf("bp_k%0d_c%0d_result", k, c), 64'(result[k]), 64'h27F);
      chk($sformatf("bp_k%0d_c%0d_sel", k, c), 64'(alu_sel[k]), 64'd1);
      chk($sformatf("bp_k%0d_c%0d_in1", k, c), 64'(alu_in1[k]), 64'hD5);
    end
    res_ready[k] = 1'b1;
    tick();
    res_ready[k] = 1'b0;
    chk($sformatf("single_k%0d_done_rvalid", k), 64'(res_valid[k]), 64'd0);
    chk($sformatf("single_k%0d_done_busy", k), 64'(busy[k]), 64'd0);
  endtask

  task automatic fill5(input int k);
    res_ready[k] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_tbl(k, i);
      chk($sformatf("fill_k%0d_rdy%0d", k, i), 64'(cmd_ready[k]), (i < 5) ? 64'd1 : 64'd0);
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("fill_k%0d_stall%0d", k, c), 64'(cmd_ready[k]), 64'd0);
      tick();
    end
    cmd_valid[k] = 1'b0;
  endtask

  task automatic drain5(input int k);
    int n = 0;
    res_ready[k] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (res_valid[k]) begin
        chk($sformatf("drain_k%0d_r%0d", k, n), 64'(result[k]), (n < 5) ? 64'(t_exp[n]) : 64'hDEAD);
        n++;
      end
      tick();
    end
    res_ready[k] = 1'b0;
    chk($sformatf("drain_k%0d_count", k), 64'(n), 64'd5);
  endtask

  task automatic reset_mid_wait(input int k);
    int seen = 0;
    fill5(k);
    chk("rst_hold_result", 64'(result[k]), 64'h1001);
    res_ready[k] = 1'b1;
    tick();
    res_ready[k] = 1'b0;
    chk("rst_wait_rvalid", 64'(res_valid[k]), 64'd0);
    chk("rst_wait_busy", 64'(busy[k]), 64'd1);
    chk("rst_wait_in0", 64'(alu_in0[k]), 64'h2);
    rst[k] = 1'b1;
    drive_tbl(k, 5);
    tick();
    chk_reset(k, "rst_mid");
    rst[k] = 1'b0;
    cmd_valid[k] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (res_valid[k] || busy[k]) seen++;
    end
    chk("rst_after_activity", 64'(seen), 64'd0);
  endtask

  task automatic stream(input int k);
    int idx = 0;
    int n = 0;
    int last = 0;
    bit acc;
    res_ready[k] = 1'b1;
    for (int j = 0; j < 100 && n < 8; j++) begin
      if (res_valid[k]) begin
        chk($sformatf("stream_k%0d_r%0d", k, n), 64'(result[k]), 64'(3 * n));
        if (n == 0) chk($sformatf("stream_k%0d_lat", k), 64'(j), 64'(3 + k));
        else        chk($sformatf("stream_k%0d_gap%0d", k, n), 64'(j - last), 64'(k + 2));
        last = j;
        n++;
      end
      if (idx < 8) begin
        cmd_valid[k] = 1'b1;
        sel[k] = 3'(idx);
        in0[k] = 32'(idx);
        in1[k] = 32'(2 * idx);
        a[k]   = 32'h0;
      end else begin
        cmd_valid[k] = 1'b0;
      end
      acc = cmd_valid[k] && cmd_ready[k];
      tick();
      if (acc) idx++;
    end
    cmd_valid[k] = 1'b0;
    res_ready[k] = 1'b0;
    chk($sformatf("stream_k%0d_count", k), 64'(n), 64'd8);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; cmd_valid[k] = 1'b0; sel[k] = '0;
      a[k] = '0; in0[k] = '0; in1[k] = '0; res_ready[k] = 1'b0;
    end
    tick();
    tick();
    chk_reset(0, "in_reset");
    chk_reset(1, "in_reset");
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick();
    chk_reset(0, "post_reset");
    chk_reset(1, "post_reset");

    single(1);
    single(0);
    fill5(1);
    drain5(1);
    reset_mid_wait(1);
    stream(1);
    stream(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_cmd_issue.md
ALU_CMD_ISSUE -- requirements
Module: alu_cmd_issue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter ALU_LAT, default 1, downstream ALU input-to-output latency in clocks (0..7).
REQ-004 SHALL use one clock and a synchronous, active-high reset: i_clk input 1 rising-edge clock; i_reset input 1 synchronous active-high reset.
REQ-005 i_cmd_valid input 1: command present.
REQ-006 o_cmd_ready output 1: FIFO can accept.
REQ-007 i_select input 3: ALU operation code.
REQ-008 i_A, i_in0, i_in1 input DATA_W each: ALU operands.
REQ-009 o_alu_select output 3; o_alu_A, o_alu_in0, o_alu_in1 output DATA_W: registered drive to ALU i_select/i_A/i_in0/i_in1.
REQ-010 i_alu_out input DATA_W: ALU o_out.
REQ-011 o_result output DATA_W; o_result_valid output 1; i_result_ready input 1: result handshake.
REQ-012 o_busy output 1: FSM not IDLE or FIFO non-empty.

Function
REQ-013 Command SHALL be written when i_cmd_valid && o_cmd_ready at a rising edge; o_cmd_ready = !full, with no write-through when full.
REQ-014 FIFO SHALL be in-order; pointers wrap modulo DEPTH; count 0..DEPTH.
REQ-015 FSM states SHALL be IDLE, WAIT, HOLD.
REQ-016 IDLE: if FIFO non-empty, pop head, register it onto o_alu_*, load counter = ALU_LAT, go WAIT; else stay.
REQ-017 WAIT: o_alu_* SHALL stay stable; counter!=0 -> decrement; counter==0 -> capture i_alu_out into o_result, set o_result_valid, go HOLD.
REQ-018 HOLD: o_result and o_alu_* stable while !i_result_ready; on i_result_ready, clear o_result_valid and, if FIFO non-empty, pop next and go WAIT in the same edge (back-to-back), else go IDLE.
REQ-019 Latency: command accepted at edge of cycle t into empty block -> o_result_valid high from cycle t+3+ALU_LAT.
REQ-020 Simultaneous push and pop in one edge SHALL both take effect; count unchanged.
REQ-021 Push when FIFO empty and FSM IDLE SHALL NOT pop in the same edge (pop one cycle later).
REQ-022 Throughput with i_result_ready tied high: one result per ALU_LAT+2 cycles.
REQ-023 i_select and operand values SHALL pass unmodified; no arithmetic in this block.

Reset
REQ-024 On i_reset at a rising edge: FSM->IDLE, FIFO pointers/count->0, counter->0, all entries discarded including in-flight command.
REQ-025 Reset values: o_alu_select=3'b000, o_alu_A/in0/in1=0, o_result=0, o_result_valid=0, o_busy=0; o_cmd_ready=1 from first cycle after reset.
REQ-026 Reset SHALL take priority over push, pop and capture in the same edge.

Structure
REQ-027 Shared package alu_pkg SHALL hold SEL_W=3, DATA_W default, FSM state type/encoding, and the packed command record {select, A, in0, in1}.
REQ-028 FIFO SHALL be a sub-module alu_cmd_fifo (storage, pointers, full/empty); FSM, counter and output registers in alu_cmd_issue.

Verification
REQ-029 Bench SHALL drive 10 ns clock, include ALU stub: o_out = in0 + in1 + A registered ALU_LAT cycles, and run ALU_LAT=0 and 1.
REQ-030 Single: select=3'b001, in0=0xD4, in1=0xD5, A=0xD6, accepted cycle t -> o_alu_* match at t+2, o_result=0x27F valid at t+4 (ALU_LAT=1).
REQ-031 Fill: 5 back-to-back commands, i_result_ready=0 -> o_cmd_ready low after 4th accept plus 1 popped (5 accepted), 6th stalls; results later emerge in push order.
REQ-032 Backpressure: hold i_result_ready=0 for 10 cycles in HOLD -> o_result, o_alu_* constant, o_result_valid stays 1, no loss.
REQ-033 Reset mid-WAIT with 3 queued -> next cycle all outputs at reset values, o_busy=0, no later result appears.
REQ-034 Streaming 8 commands in0=i, in1=2i, A=0, ready tied 1 -> results 3i in order, spacing ALU_LAT+2 cycles.
